data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the rv32i core: the memory-side end of the load/store interface driven by the core's `mem_write` / `lw` / `sw` control path. It accepts one word-aligned load or store request at a time over a valid/ready handshake and holds it for a programmable number of wait states. It then performs the access on an internal word-organised RAM with byte-lane strobes and returns read data and an error flag over a second valid/ready handshake. It is the data-side counterpart of the instruction fetch path and replaces the combinational data RAM once the core is made stall-capable.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words in the RAM; power of two, ≥ 2.
- `WAIT_CYCLES`, 2: extra cycles between request acceptance and response; 0 allowed.
- `clk_i` in 1: clock; all state changes on rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: responder can accept a request.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_addr_i` in 32: byte address.
- `req_wdata_i` in 32: store data.
- `req_be_i` in 4: byte-lane enables for stores; bit n enables `wdata[8n+7:8n]`. Ignored for loads.
- `rsp_valid_o` out 1: response present.
- `rsp_ready_i` in 1: consumer accepts response.
- `rsp_rdata_o` out 32: load data; 0 for stores and errors.
- `rsp_err_o` out 1: request was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - `req_ready_o`=1.
  - On `req_valid_i & req_ready_o`, capture we/addr/wdata/be.
  - If `WAIT_CYCLES`=0, perform the access and go to RESP; otherwise load the counter with `WAIT_CYCLES-1` and go to WAIT.
- WAIT:
  - `req_ready_o`=0.
  - When the counter is 0, perform the access and go to RESP; otherwise decrement.
  - Counter width is `max(1, $clog2(WAIT_CYCLES+1))`.
- RESP:
  - `req_ready_o`=0 and `rsp_valid_o`=1.
  - `rsp_rdata_o` and `rsp_err_o` are registered and held stable until `rsp_valid_o & rsp_ready_i`, then go to IDLE.
  - The next request is not accepted in that same cycle. There is no pipelining; at most one request is outstanding.
- Access rules:
  - Word index is `addr[2 +: $clog2(DEPTH_WORDS)]`.
  - Error if `addr[1:0]`≠0 or `addr[31:2]` ≥ `DEPTH_WORDS`.
  - On error: RAM unchanged, `rsp_rdata_o`=0, `rsp_err_o`=1.
  - Store: each lane with its be bit set is written; other lanes keep their value. `be`=0000 is a legal no-op store, err=0. `rsp_rdata_o`=0.
  - Load: `rsp_rdata_o` is the full word at the index, err=0.
- RAM contents are not reset; they are undefined until written.
- Input changes while `req_ready_o`=0 are ignored. Captured values are used, not live inputs.

## Timing
- Reset (asserted): `req_ready_o`=0, `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0, counter 0, state IDLE.
- After release: `req_ready_o`=1 from the first cycle.
- Request accepted at rising edge k: `rsp_valid_o` is high from edge k+`WAIT_CYCLES`+1 onward.
- The RAM write for a store occurs at that same edge.
- Back-to-back throughput: one request per `WAIT_CYCLES`+2 cycles with `rsp_ready_i` tied high.
- Store followed by a load to the same word returns the new data; the write completes before the load is accepted.
- Reset mid-operation (WAIT or RESP) abandons the request:
  - A store still in WAIT does not modify RAM.
  - A store already in RESP has already been written.
  - No response is issued after reset.
- Response backpressure: `rsp_ready_i` low for N cycles extends RESP by N cycles with outputs unchanged.

## Test plan
- Store then load: `WAIT_CYCLES`=2, `sw` 0xDEADBEEF to 0x10, then `lw` 0x10.
  - Each `rsp_valid_o` rises 3 edges after its accept.
  - The load returns 0xDEADBEEF with err=0.
- Byte strobes: write 0x11223344 to 0x20, then store 0xAABBCCDD with be=0101, then load 0x20 → 0x11BB33DD.
- Errors:
  - Load 0x22 → err=1, rdata=0.
  - Store to byte address 4×`DEPTH_WORDS` → err=1; the location wrapping to index 0 is unchanged.
  - A store to the last word (4×`DEPTH_WORDS`−4) succeeds.
- Backpressure: hold `rsp_ready_i`=0 for 5 cycles during a load.
  - `rsp_valid_o`/`rsp_rdata_o` stay stable.
  - `req_ready_o` stays 0 throughout, even though a new `req_valid_i` is pending.
  - The pending request is accepted only in the cycle after the response handshake.
- Zero wait: `WAIT_CYCLES`=0, continuous alternating stores and loads with `rsp_ready_i`=1 → one response every 2 cycles, data correct.
- Reset in WAIT: store 0x55 to 0x30 (previously 0x0), assert `rst_ni` during WAIT.
  - All outputs go to reset values immediately.
  - After release, loading 0x30 returns 0x0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES, then accesses a
// byte-strobed word RAM and returns read data plus an error flag over a valid/ready handshake.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] CntInit = (WAIT_CYCLES == 0) ? '0 : CW'(WAIT_CYCLES - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q;
    logic [31:0]   addr_q, wdata_q;
    logic [3:0]    be_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          do_access;

    logic          acc_we;
    logic [31:0]   acc_addr, acc_wdata;
    logic [3:0]    acc_be;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic          mem_we;

    logic [31:0]   mem_q [DEPTH_WORDS];

    assign req_ready_o = rst_ni && (state_q == StIdle);
    assign rsp_valid_o = (state_q == StResp);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    // With zero wait states the access happens on the accept edge, so use live inputs there.
    always_comb begin
        if (state_q == StIdle) begin
            acc_we    = req_we_i;
            acc_addr  = req_addr_i;
            acc_wdata = req_wdata_i;
            acc_be    = req_be_i;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
    end

    assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH_WORDS));
    assign acc_idx = acc_addr[2 +: AW];
    assign mem_we  = do_access && acc_we && !acc_err;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_access = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    if (WAIT_CYCLES == 0) begin
                        do_access = 1'b1;
                        state_d   = StResp;
                    end else begin
                        cnt_d   = CntInit;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    do_access = 1'b1;
                    state_d   = StResp;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (do_access) begin
            err_d   = acc_err;
            rdata_d = (acc_we || acc_err) ? 32'h0 : mem_q[acc_idx];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (state_q == StIdle && req_valid_i) begin
                we_q    <= req_we_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                be_q    <= req_be_i;
            end
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && acc_be[b]) begin
                mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance with two wait states, one with none.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        v2, we2, rr2, rdy2, rv2, er2;
    logic [31:0] a2, wd2, rd2;
    logic [3:0]  be2;
    logic        v0, we0, rr0, rdy0, rv0, er0;
    logic [31:0] a0, wd0, rd0;
    logic [3:0]  be0;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v2), .req_ready_o(rdy2), .req_we_i(we2),
        .req_addr_i(a2), .req_wdata_i(wd2), .req_be_i(be2), .rsp_valid_o(rv2),
        .rsp_ready_i(rr2), .rsp_rdata_o(rd2), .rsp_err_o(er2)
    );

    data_mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v0), .req_ready_o(rdy0), .req_we_i(we0),
        .req_addr_i(a0), .req_wdata_i(wd0), .req_be_i(be0), .rsp_valid_o(rv0),
        .rsp_ready_i(rr0), .rsp_rdata_o(rd0), .rsp_err_o(er0)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          vcyc;
    } exp_t;

    exp_t q2[$];
    exp_t q0[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitors sample 1 time unit after the falling edge, after drivers have settled.
    logic seen2 = 1'b0;
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            seen2 = 1'b0;
        end else if (rv2) begin
            if (q2.size() == 0) begin
                chk("w2 unexpected response", 32'(rv2), 32'h0);
            end else begin
                if (!seen2) chk("w2 response latency", 32'(cyc), 32'(q2[0].vcyc));
                chk("w2 rdata", rd2, q2[0].rdata);
                chk("w2 err", 32'(er2), 32'(q2[0].err));
                chk("w2 req_ready during response", 32'(rdy2), 32'h0);
                if (rr2) void'(q2.pop_front());
            end
            seen2 = !rr2;
        end else begin
            seen2 = 1'b0;
        end
    end

    logic seen0 = 1'b0;
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            seen0 = 1'b0;
        end else if (rv0) begin
            if (q0.size() == 0) begin
                chk("w0 unexpected response", 32'(rv0), 32'h0);
            end else begin
                if (!seen0) chk("w0 response latency", 32'(cyc), 32'(q0[0].vcyc));
                chk("w0 rdata", rd0, q0[0].rdata);
                chk("w0 err", 32'(er0), 32'(q0[0].err));
                chk("w0 req_ready during response", 32'(rdy0), 32'h0);
                if (rr0) void'(q0.pop_front());
            end
            seen0 = !rr0;
        end else begin
            seen0 = 1'b0;
        end
    end

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic issue(input bit z, input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] er, input bit ee,
                         output int acc);
        exp_t e;
        int   n;
        bit   rdy;
        acc = -1;
        if (z) begin
            v0 = 1'b1; we0 = we; a0 = a; wd0 = wd; be0 = be;
        end else begin
            v2 = 1'b1; we2 = we; a2 = a; wd2 = wd; be2 = be;
        end
        n   = 0;
        rdy = z ? rdy0 : rdy2;
        while (!rdy && n < 100) begin
            @(negedge clk);
            n++;
            rdy = z ? rdy0 : rdy2;
        end
        if (!rdy) begin
            chk("accept timeout", 32'(rdy), 32'h1);
        end else begin
            acc     = cyc;
            e.rdata = er;
            e.err   = ee;
            e.vcyc  = cyc + (z ? 0 : 2) + 1;
            if (z) q0.push_back(e);
            else q2.push_back(e);
        end
        @(negedge clk);
        if (z) v0 = 1'b0;
        else v2 = 1'b0;
    endtask

    task automatic drain(input bit z);
        int n = 0;
        while ((z ? q0.size() : q2.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain timeout", 32'(n), 32'h0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [31:0] zd [4] = '{32'h01020304, 32'hA5A5A5A5, 32'h0000FFFF, 32'h80000001};

    initial begin
        int acc, a1, prev;
        rst_n = 1'b0;
        v2 = 0; we2 = 0; a2 = 0; wd2 = 0; be2 = 0; rr2 = 1;
        v0 = 0; we0 = 0; a0 = 0; wd0 = 0; be0 = 0; rr0 = 1;
        @(negedge clk);
        chk("reset req_ready", 32'(rdy2), 32'h0);
        chk("reset rsp_valid", 32'(rv2), 32'h0);
        chk("reset rsp_rdata", rd2, 32'h0);
        chk("reset rsp_err", 32'(er2), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("req_ready after release", 32'(rdy2), 32'h1);
        @(negedge clk);

        // Store then load
        issue(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, acc);
        issue(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, acc);
        // Byte strobes
        issue(0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0, 0, acc);
        issue(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 0, acc);
        issue(0, 0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 0, acc);
        // Errors and range boundary
        issue(0, 0, 32'h22, 32'h0, 4'h0, 32'h0, 1, acc);
        issue(0, 1, 32'h0, 32'h12345678, 4'hF, 32'h0, 0, acc);
        issue(0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1, acc);
        issue(0, 0, 32'h0, 32'h0, 4'h0, 32'h12345678, 0, acc);
        issue(0, 1, 32'h3FC, 32'hCAFEF00D, 4'hF, 32'h0, 0, acc);
        issue(0, 0, 32'h3FC, 32'h0, 4'h0, 32'hCAFEF00D, 0, acc);
        drain(0);

        // Backpressure: response held 5 cycles while a new request waits
        rr2 = 1'b0;
        issue(0, 0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 0, a1);
        fork
            begin
                repeat (7) @(negedge clk);
                rr2 = 1'b1;
            end
            issue(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, acc);
        join
        chk("backpressure next accept cycle", 32'(acc), 32'(a1 + 9));
        drain(0);

        // Reset during WAIT abandons the store
        issue(0, 1, 32'h30, 32'h0, 4'hF, 32'h0, 0, acc);
        issue(0, 0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 0, acc);
        drain(0);
        issue(0, 1, 32'h30, 32'h55, 4'hF, 32'h0, 0, acc);
        rst_n = 1'b0;
        q2.delete();
        #1;
        chk("mid-reset req_ready", 32'(rdy2), 32'h0);
        chk("mid-reset rsp_valid", 32'(rv2), 32'h0);
        chk("mid-reset rsp_rdata", rd2, 32'h0);
        chk("mid-reset rsp_err", 32'(er2), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        issue(0, 0, 32'h30, 32'h0, 4'h0, 32'h0, 0, acc);
        drain(0);

        // Zero wait states: alternating stores and loads, one response per 2 cycles
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            issue(1, 1, 32'(4 * i), zd[i], 4'hF, 32'h0, 0, acc);
            if (prev >= 0) chk("w0 accept spacing", 32'(acc - prev), 32'h2);
            prev = acc;
            issue(1, 0, 32'(4 * i), 32'h0, 4'h0, zd[i], 0, acc);
            chk("w0 accept spacing", 32'(acc - prev), 32'h2);
            prev = acc;
        end
        issue(1, 1, 32'h4, 32'hFFFFFFFF, 4'h0, 32'h0, 0, acc);
        issue(1, 0, 32'h4, 32'h0, 4'h0, zd[1], 0, acc);
        issue(1, 1, 32'h40, 32'hFFFFFFFF, 4'hF, 32'h0, 1, acc);
        issue(1, 0, 32'h0, 32'h0, 4'h0, zd[0], 0, acc);
        drain(1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
